// File: rtl/oc_clock_meter.sv
// Clock presence/frequency meter: decodes a chip-wide clock ID, counts that clock's
// synchronized tick pulses over a fixed window of local cycles, and returns the count.
module oc_clock_meter #(
    parameter int NumSeRef     = 2,
    parameter int NumDiffRef   = 2,
    parameter int NumPll       = 4,
    parameter int WindowCycles = 100000,
    parameter int CountWidth   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_clock_id,
    input  logic [NumSeRef-1:0]   tick_se,
    input  logic [NumDiffRef-1:0] tick_diff,
    input  logic [NumPll-1:0]     tick_pll,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_error,
    output logic [31:0]           resp_clock_id,
    output logic [CountWidth-1:0] resp_count
);

    localparam int              WinW    = $clog2(WindowCycles);
    localparam logic [WinW-1:0] WinLoad = WinW'(WindowCycles - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_MEASURE,
        S_RESPOND
    } state_e;

    typedef enum logic [1:0] {
        CLS_SE,
        CLS_DIFF,
        CLS_PLL
    } cls_e;

    // Counting stops at all-ones so a very fast clock reads as "at least" rather than wrapping.
    function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CountWidth'(1);
    endfunction

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic [31:0]           id_q, id_d;
    cls_e                  cls_q, cls_d;
    logic [6:0]            idx_q, idx_d;
    logic [WinW-1:0]       win_q, win_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  resp_error_q, resp_error_d;
    logic [CountWidth-1:0] resp_count_q, resp_count_d;

    logic                  dec_ok;
    cls_e                  dec_cls;
    logic [31:0]           dec_off;
    logic                  tick_sel;
    logic [CountWidth-1:0] cnt_next;

    // Class ranges are 100 IDs wide; IDs past the implemented count of a class are errors.
    always_comb begin
        dec_ok  = 1'b0;
        dec_cls = CLS_SE;
        dec_off = id_q;
        if (id_q < 32'd100) begin
            dec_cls = CLS_SE;
            dec_off = id_q;
            dec_ok  = dec_off < 32'(NumSeRef);
        end else if (id_q < 32'd200) begin
            dec_cls = CLS_DIFF;
            dec_off = id_q - 32'd100;
            dec_ok  = dec_off < 32'(NumDiffRef);
        end else if (id_q < 32'd300) begin
            dec_cls = CLS_PLL;
            dec_off = id_q - 32'd200;
            dec_ok  = dec_off < 32'(NumPll);
        end
    end

    always_comb begin
        tick_sel = 1'b0;
        case (cls_q)
            CLS_SE: begin
                for (int i = 0; i < NumSeRef; i++) begin
                    if (idx_q == 7'(i)) tick_sel = tick_se[i];
                end
            end
            CLS_DIFF: begin
                for (int i = 0; i < NumDiffRef; i++) begin
                    if (idx_q == 7'(i)) tick_sel = tick_diff[i];
                end
            end
            CLS_PLL: begin
                for (int i = 0; i < NumPll; i++) begin
                    if (idx_q == 7'(i)) tick_sel = tick_pll[i];
                end
            end
            default: tick_sel = 1'b0;
        endcase
    end

    assign cnt_next = tick_sel ? sat_inc(cnt_q) : cnt_q;

    always_comb begin
        state_d      = state_q;
        req_ready_d  = 1'b0;
        id_d         = id_q;
        cls_d        = cls_q;
        idx_d        = idx_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_error_d = resp_error_q;
        resp_count_d = resp_count_q;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d  = 1'b0;
                    id_d         = req_clock_id;
                    cnt_d        = '0;
                    resp_error_d = 1'b0;
                    resp_count_d = '0;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                idx_d = dec_off[6:0];
                if (dec_ok) begin
                    win_d   = WinLoad;
                    state_d = S_MEASURE;
                end else begin
                    resp_error_d = 1'b1;
                    resp_count_d = '0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESPOND;
                end
            end
            S_MEASURE: begin
                // The final window cycle's tick is folded straight into the response.
                cnt_d = cnt_next;
                if (win_q == '0) begin
                    resp_count_d = cnt_next;
                    resp_error_d = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESPOND;
                end else begin
                    win_d = win_q - WinW'(1);
                end
            end
            S_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            id_q         <= '0;
            cls_q        <= CLS_SE;
            idx_q        <= '0;
            win_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            id_q         <= id_d;
            cls_q        <= cls_d;
            idx_q        <= idx_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_count_q <= resp_count_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_error    = resp_error_q;
    assign resp_clock_id = id_q;
    assign resp_count    = resp_count_q;

endmodule

// File: tb/tb_oc_clock_meter.sv
// Bench for oc_clock_meter: two instances (8-bit and 4-bit counters) share all stimulus and
// are compared every cycle against a transaction-level model, plus literal expectations.
module tb_oc_clock_meter;

    localparam int WIN = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_clock_id = '0;
    logic [1:0]  tick_se = '0;
    logic [1:0]  tick_diff = '0;
    logic [3:0]  tick_pll = '0;

    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_clock_id;
    logic [7:0]  resp_count;
    logic        req_ready_s, resp_valid_s, resp_error_s;
    logic [31:0] resp_clock_id_s;
    logic [3:0]  resp_count_s;

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int tc = 0;

    oc_clock_meter #(.NumSeRef(2), .NumDiffRef(2), .NumPll(4), .WindowCycles(WIN), .CountWidth(8)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_clock_id(req_clock_id), .tick_se(tick_se), .tick_diff(tick_diff), .tick_pll(tick_pll),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_error(resp_error),
        .resp_clock_id(resp_clock_id), .resp_count(resp_count));

    oc_clock_meter #(.NumSeRef(2), .NumDiffRef(2), .NumPll(4), .WindowCycles(WIN), .CountWidth(4)) dut_s (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_clock_id(req_clock_id), .tick_se(tick_se), .tick_diff(tick_diff), .tick_pll(tick_pll),
        .resp_valid(resp_valid_s), .resp_ready(resp_ready), .resp_error(resp_error_s),
        .resp_clock_id(resp_clock_id_s), .resp_count(resp_count_s));

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Tick patterns, advanced shortly after each rising edge.
    always @(posedge clock) begin
        #1;
        tc++;
        case (mode)
            1: begin
                tick_pll  = tc[0] ? 4'b1011 : 4'b0100;
                tick_se   = {tc[0], ~tc[0]};
                tick_diff = {~tc[0], tc[0]};
            end
            2: begin tick_diff = {tc[0], 1'b1}; tick_se = 2'b00; tick_pll = 4'hF; end
            3: begin tick_se = 2'b01; tick_diff = 2'b11; tick_pll = 4'h0; end
            4: begin tick_pll = {2'b11, (tc % 4 == 0), 1'b1}; tick_se = 2'b11; tick_diff = 2'b11; end
            5: begin tick_se = 2'($urandom); tick_diff = 2'($urandom); tick_pll = 4'($urandom); end
            default: begin tick_se = '0; tick_diff = '0; tick_pll = '0; end
        endcase
    end

    // Transaction-level model: one request in flight; the response appears a fixed number
    // of edges after acceptance and counts the selected tick over the window edges.
    bit          m_busy = 0, m_req_ready = 0, m_resp_valid = 0, m_err = 0;
    logic [31:0] m_id = '0;
    int          m_raw = 0, m_acc = 0, cyc = 0;

    function automatic bit id_ok(input logic [31:0] id);
        return (id < 2) || (id >= 100 && id < 102) || (id >= 200 && id < 204);
    endfunction

    function automatic bit tick_of(input logic [31:0] id, input logic [1:0] se,
                                   input logic [1:0] df, input logic [3:0] pl);
        logic [31:0] off;
        if (id < 100) return se[id[0]];
        if (id < 200) begin off = id - 100; return df[off[0]]; end
        off = id - 200;
        return pl[off[1:0]];
    endfunction

    function automatic logic [31:0] exp_cnt(input int raw, input bit err, input int maxv);
        if (err) return 0;
        return (raw > maxv) ? maxv : raw;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_req_ready = 0; m_resp_valid = 0; m_err = 0; m_id = '0; m_raw = 0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (req_valid && m_req_ready) begin
                    m_busy = 1; m_acc = cyc; m_id = req_clock_id; m_raw = 0; m_err = 0; m_req_ready = 0;
                end else begin
                    m_req_ready = 1;
                end
            end else if (!m_resp_valid) begin
                if (!id_ok(m_id)) begin
                    if (cyc - m_acc == 1) begin m_resp_valid = 1; m_err = 1; end
                end else if (cyc - m_acc >= 2 && cyc - m_acc <= WIN + 1) begin
                    if (tick_of(m_id, tick_se, tick_diff, tick_pll)) m_raw++;
                    if (cyc - m_acc == WIN + 1) m_resp_valid = 1;
                end
            end else if (resp_ready) begin
                m_resp_valid = 0; m_busy = 0; m_req_ready = 1;
            end
        end
    end

    always @(negedge clock) begin
        chk("req_ready", 32'(req_ready), 32'(m_req_ready));
        chk("req_ready_s", 32'(req_ready_s), 32'(m_req_ready));
        chk("resp_valid", 32'(resp_valid), 32'(m_resp_valid));
        chk("resp_valid_s", 32'(resp_valid_s), 32'(m_resp_valid));
        if (m_resp_valid || reset) begin
            chk("resp_error", 32'(resp_error), 32'(m_err));
            chk("resp_error_s", 32'(resp_error_s), 32'(m_err));
            chk("resp_clock_id", resp_clock_id, m_id);
            chk("resp_clock_id_s", resp_clock_id_s, m_id);
            chk("resp_count", 32'(resp_count), exp_cnt(m_raw, m_err, 255));
            chk("resp_count_s", 32'(resp_count_s), exp_cnt(m_raw, m_err, 15));
        end
    end

    task automatic send_req(input logic [31:0] id);
        bit ok;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_clock_id = id;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("accept_wait");
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic get_resp(input int hold, output int lat, output logic err,
                            output logic [31:0] cid, output logic [7:0] c8, output logic [3:0] c4);
        bit seen;
        lat = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            lat++;
            if (resp_valid) begin seen = 1; break; end
        end
        if (!seen) fail_now("resp_wait");
        err = resp_error;
        cid = resp_clock_id;
        c8  = resp_count;
        c4  = resp_count_s;
        repeat (hold) @(negedge clock);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
    endtask

    int          lat;
    logic        err;
    logic [31:0] cid;
    logic [7:0]  c8;
    logic [3:0]  c4;
    logic [31:0] extra_ids [10] = '{32'd1, 32'd101, 32'd203, 32'd99, 32'd199,
                                   32'd299, 32'd204, 32'd102, 32'hFFFF_FFFF, 32'd3};

    initial begin
        // Post-reset state
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_clock_id", resp_clock_id, 32'd0);
        chk("rst_resp_count", 32'(resp_count), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("ready_after_edge", 32'(req_ready), 32'd1);

        // Valid PLL measurement
        mode = 1;
        send_req(32'd202);
        get_resp(0, lat, err, cid, c8, c4);
        chk("pll_latency", 32'(lat), 32'd18);
        chk("pll_error", 32'(err), 32'd0);
        chk("pll_id", cid, 32'd202);
        chk("pll_count", 32'(c8), 32'd8);
        chk("pll_count_s", 32'(c4), 32'd8);

        // Invalid IDs; resp_ready raised early for the first one
        resp_ready = 1'b1;
        send_req(32'd150);
        get_resp(0, lat, err, cid, c8, c4);
        chk("id150_latency", 32'(lat), 32'd2);
        chk("id150_error", 32'(err), 32'd1);
        chk("id150_count", 32'(c8), 32'd0);
        send_req(32'd300);
        get_resp(0, lat, err, cid, c8, c4);
        chk("id300_latency", 32'(lat), 32'd2);
        chk("id300_error", 32'(err), 32'd1);
        chk("id300_count", 32'(c8), 32'd0);
        chk("id300_id", cid, 32'd300);
        send_req(32'd2);
        get_resp(0, lat, err, cid, c8, c4);
        chk("id2_error", 32'(err), 32'd1);
        chk("id2_latency", 32'(lat), 32'd2);

        // Backpressure
        mode = 2;
        send_req(32'd100);
        get_resp(10, lat, err, cid, c8, c4);
        chk("bp_latency", 32'(lat), 32'd18);
        chk("bp_count", 32'(c8), 32'd16);
        chk("bp_count_s", 32'(c4), 32'd15);
        chk("bp_error", 32'(err), 32'd0);
        @(negedge clock);
        chk("bp_ready_after_hs", 32'(req_ready), 32'd1);

        // Saturation on the 4-bit instance
        mode = 3;
        send_req(32'd0);
        get_resp(2, lat, err, cid, c8, c4);
        chk("sat_count_s", 32'(c4), 32'd15);
        chk("sat_count", 32'(c8), 32'd16);

        // Reset in the middle of a measurement
        mode = 4;
        send_req(32'd201);
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_id", resp_clock_id, 32'd0);
        chk("midrst_count", 32'(resp_count), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("midrst_no_resp", 32'(resp_valid), 32'd0);
        send_req(32'd201);
        get_resp(1, lat, err, cid, c8, c4);
        chk("after_rst_count", 32'(c8), 32'd4);
        chk("after_rst_error", 32'(err), 32'd0);
        chk("after_rst_latency", 32'(lat), 32'd18);

        // Boundary IDs under random ticks, checked by the model
        mode = 5;
        for (int i = 0; i < 10; i++) begin
            send_req(extra_ids[i]);
            get_resp(i % 3, lat, err, cid, c8, c4);
            chk("extra_error", 32'(err), 32'(!id_ok(extra_ids[i])));
        end

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time bound expired");
        $fatal(1);
    end

endmodule
